// File: rtl/rns_pkg.sv
// Shared helpers for the RNS {2^N+1, 2^N, 2^N-1} reverse converter.
package rns_pkg;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;
  localparam int unsigned W_MAX = 2 * N_MAX;

  // Width of the Y path (W = 2N) for a given residue width.
  function automatic int unsigned width_w(input int unsigned n);
    return 2 * n;
  endfunction

  // Dynamic range M = (2^N+1) * 2^N * (2^N-1).
  function automatic logic [63:0] modulus_product(input int unsigned n);
    logic [63:0] p;
    p = 64'd1 << n;
    return (p + 64'd1) * p * (p - 64'd1);
  endfunction

  // Addition modulo 2^w-1 on operands already below 2^w.
  // End-around carry taken from p+q+1, so the all-ones code never appears.
  function automatic logic [W_MAX-1:0] mod_add_2w(input logic [W_MAX-1:0] p,
                                                  input logic [W_MAX-1:0] q,
                                                  input int unsigned w);
    logic [W_MAX:0] raw;
    logic [W_MAX:0] inc;
    logic [W_MAX:0] mask;
    logic [W_MAX:0] carry;
    raw   = {1'b0, p} + {1'b0, q};
    inc   = raw + (W_MAX + 1)'(1);
    mask  = ((W_MAX + 1)'(1) << w) - (W_MAX + 1)'(1);
    carry = inc >> w;
    if (carry[0]) begin
      return W_MAX'(inc & mask);
    end
    return W_MAX'(raw & mask);
  endfunction

endpackage

// File: rtl/rns_mod_add_pm1.sv
// Combinational adder modulo 2^W-1 (result never all-ones).
module rns_mod_add_pm1
  import rns_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W_MAX-1:0] a_ext;
  logic [W_MAX-1:0] b_ext;

  // Zero-extend operands to the package's fixed helper width.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[W-1:0] = a;
    b_ext[W-1:0] = b;
  end

  assign sum = W'(mod_add_2w(a_ext, b_ext, W));

endmodule

// File: rtl/rns_reverse_converter_pipe.sv
// Pipelined RNS-to-binary converter for moduli {2^N+1, 2^N, 2^N-1}.
// Three registered stages with a single global stall (adv).
module rns_reverse_converter_pipe
  import rns_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N:0]     x1,
  input  logic [N-1:0]   x2,
  input  logic [N-1:0]   x3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*N-1:0] out,
  output logic           out_err
);

  localparam int unsigned W = width_w(N);
  localparam logic [N:0] TWO_POW_N = {1'b1, {N{1'b0}}};

  logic         adv;
  logic [W-1:0] a1;
  logic [W-1:0] a2;
  logic [W-1:0] a3;
  logic [W-1:0] d1;
  logic [W-1:0] s23;
  logic [W-1:0] y;
  logic         err_in;

  // Stage 1 registers
  logic         v1;
  logic [W-1:0] d1_q;
  logic [W-1:0] s23_q;
  logic [N-1:0] x2_q1;
  logic         err_q1;

  // Stage 2 registers
  logic         v2;
  logic [W-1:0] y_q;
  logic [N-1:0] x2_q2;
  logic         err_q2;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Coefficients: a1 and a3 are two copies of a rotated residue.
  for (genvar g = 0; g < 2; g++) begin : g_coef
    assign a1[g*N +: N] = {x1[N] ^ x1[0], x1[N-1:1]};
    assign a3[g*N +: N] = {x3[0], x3[N-1:1]};
  end

  assign a2     = {~x2, {N{1'b1}}};
  assign d1     = a1 - W'(x1);
  assign err_in = x1 > TWO_POW_N;

  rns_mod_add_pm1 #(.W(W)) u_add_23 (
    .a   (a2),
    .b   (a3),
    .sum (s23)
  );

  rns_mod_add_pm1 #(.W(W)) u_add_y (
    .a   (d1_q),
    .b   (s23_q),
    .sum (y)
  );

  // Stage 1: capture d1, partial sum a2+a3, x2 and the range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      d1_q   <= '0;
      s23_q  <= '0;
      x2_q1  <= '0;
      err_q1 <= 1'b0;
    end else if (adv) begin
      v1     <= in_valid;
      d1_q   <= d1;
      s23_q  <= s23;
      x2_q1  <= x2;
      err_q1 <= in_valid & err_in;
    end
  end

  // Stage 2: final modular sum Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      y_q    <= '0;
      x2_q2  <= '0;
      err_q2 <= 1'b0;
    end else if (adv) begin
      v2     <= v1;
      y_q    <= y;
      x2_q2  <= x2_q1;
      err_q2 <= v1 & err_q1;
    end
  end

  // Stage 3: output register; invalid inputs produce a zero result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      out       <= err_q2 ? '0 : {y_q, x2_q2};
      out_err   <= v2 & err_q2;
    end
  end

endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// Scoreboard bench: N=10 and N=2 converters checked against CRT residues.
module tb_rns_reverse_converter_pipe;

  localparam longint unsigned M10 = 64'd1025 * 64'd1024 * 64'd1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_mode = 1'b1;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned val;
    bit              err;
    bit              lat;
    int              cyc;
  } exp_t;

  exp_t q10[$];
  exp_t q2[$];

  // N=10 instance
  logic        in_valid10 = 1'b0;
  logic        in_ready10;
  logic [10:0] x1_10 = '0;
  logic [9:0]  x2_10 = '0;
  logic [9:0]  x3_10 = '0;
  logic        out_valid10;
  logic        out_ready10 = 1'b1;
  logic [29:0] out10;
  logic        out_err10;

  // N=2 instance
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [2:0]  x1_2 = '0;
  logic [1:0]  x2_2 = '0;
  logic [1:0]  x3_2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [5:0]  out2;
  logic        out_err2;

  rns_reverse_converter_pipe #(.N(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
    .x1(x1_10), .x2(x2_10), .x3(x3_10), .out_valid(out_valid10),
    .out_ready(out_ready10), .out(out10), .out_err(out_err10)
  );

  rns_reverse_converter_pipe #(.N(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .x1(x1_2), .x2(x2_2), .x3(x3_2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out(out2), .out_err(out_err2)
  );

  function automatic void chk(input string name, input longint unsigned act,
                              input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Consumer back-pressure for the N=10 instance.
  always @(posedge clk) begin
    #1;
    out_ready10 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor N=10: handshake rule, stall hold, scoreboard pop.
  logic        stall10 = 1'b0;
  logic [29:0] hold_out10 = '0;
  logic        hold_err10 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall10 = 1'b0;
    end else begin
      chk("in_ready10", in_ready10, (!out_valid10 || out_ready10));
      if (stall10) begin
        chk("hold_valid10", out_valid10, 1);
        chk("hold_out10", out10, hold_out10);
        chk("hold_err10", out_err10, hold_err10);
      end
      if (out_valid10 && out_ready10) begin
        if (q10.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_out10 actual=%0d required=no_output", out10);
        end else begin
          e = q10.pop_front();
          chk("out10", out10, e.val);
          chk("err10", out_err10, e.err);
          if (e.lat) chk("latency10", cyc - e.cyc, 3);
        end
      end
      stall10    = out_valid10 && !out_ready10;
      hold_out10 = out10;
      hold_err10 = out_err10;
    end
  end

  // Monitor N=2: scoreboard pop and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_out2 actual=%0d required=no_output", out2);
      end else begin
        e = q2.pop_front();
        chk("out2", out2, e.val);
        chk("err2", out_err2, e.err);
        if (e.lat) chk("latency2", cyc - e.cyc, 3);
      end
    end
  end

  task automatic send10(input logic [10:0] a, input logic [9:0] b, input logic [9:0] c,
                        input longint unsigned ev, input bit er);
    bit   done = 1'b0;
    exp_t e;
    in_valid10 = 1'b1;
    x1_10 = a;
    x2_10 = b;
    x3_10 = c;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready10) begin
        e.val = ev; e.err = er; e.lat = lat_mode; e.cyc = cyc;
        q10.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid10 = 1'b0;
    x1_10 = 11'($urandom);
    x2_10 = 10'($urandom);
    x3_10 = 10'($urandom);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout10 actual=no_accept required=accept");
    end
  endtask

  task automatic send_x10(input longint unsigned xv, input bit alt_x3);
    longint unsigned c;
    c = xv % 1023;
    if (alt_x3 && c == 0) c = 1023;
    send10(11'(xv % 1025), 10'(xv % 1024), 10'(c), xv, 1'b0);
  endtask

  task automatic send_bad10();
    send10(11'($urandom_range(1025, 2047)), 10'($urandom), 10'($urandom), 0, 1'b1);
  endtask

  task automatic send2(input longint unsigned xv);
    bit   done = 1'b0;
    exp_t e;
    in_valid2 = 1'b1;
    x1_2 = 3'(xv % 5);
    x2_2 = 2'(xv % 4);
    x3_2 = 2'(xv % 3);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready2) begin
        e.val = xv; e.err = 1'b0; e.lat = lat_mode; e.cyc = cyc;
        q2.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout2 actual=no_accept required=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q10.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain10", q10.size(), 0);
    chk("drain2", q2.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid10", out_valid10, 0);
    chk("rst_out10", out10, 0);
    chk("rst_out_err10", out_err10, 0);
    chk("rst_out_valid2", out_valid2, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready10", in_ready10, 1);
    chk("rst_in_ready2", in_ready2, 1);
    @(posedge clk);
    #1;

    // Directed values at full rate
    send10(11'd1, 10'd1, 10'd1, 1, 1'b0);
    send10(11'd1024, 10'd1023, 10'd1022, M10 - 1, 1'b0);
    send10(11'd664, 10'd277, 10'd126, 123456789, 1'b0);
    send10(11'd1030, 10'd5, 10'd5, 0, 1'b1);
    send_x10(5000, 1'b0);
    send_x10(0, 1'b1);
    send_x10(64'd1023 * 777, 1'b1);
    send10(11'd2047, 10'd0, 10'd0, 0, 1'b1);
    send_x10(M10 - 1, 1'b0);
    drain();

    // N=2 exhaustive sweep, back-to-back
    for (longint unsigned xv = 0; xv < 60; xv++) send2(xv);
    drain();

    // Random stream with random back-pressure and idle gaps
    lat_mode = 1'b0;
    rand_rdy = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 15);
      if (r == 0) send_bad10();
      else if (r == 1) send_x10(64'd1023 * longint'($urandom_range(0, 1049599)), 1'b1);
      else send_x10(longint'($urandom) % M10, 1'b0);
    end
    rand_rdy = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with three items in flight
    lat_mode = 1'b1;
    send_x10(111, 1'b0);
    send_x10(222, 1'b0);
    send_x10(333, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid10", out_valid10, 0);
    chk("midrst_out10", out10, 0);
    chk("midrst_in_ready10", in_ready10, 1);
    q10.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_x10(424242, 1'b0);
    send_x10(987654321, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
